window_peak_detect: RTL and testbench

WINDOW_PEAK_DETECT -- requirements
Module: window_peak_detect

---
 rtl/dac_dig_pkg.sv | 18 +
 rtl/comp2_sel.sv | 16 +
 rtl/window_peak_detect.sv | 70 +++++++
 tb/tb_window_peak_detect.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_dig_pkg.sv
// Shared DAC digital definitions: extreme-tracking mode encodings and a
// constant-foldable ceiling log2 for sizing index fields.
package dac_dig_pkg;

   typedef enum logic {
      MODE_MAX = 1'b0,
      MODE_MIN = 1'b1
   } mode_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/comp2_sel.sv
// Decides whether a new sample replaces the running extreme; ties favour
// the newer sample in both modes.
module comp2_sel
   import dac_dig_pkg::*;
#(
   parameter int W = 6
) (
   input  logic [W-1:0] New,
   input  logic [W-1:0] Cur,
   input  logic         Mode,
   output logic         Take
);

   assign Take = (Mode == logic'(MODE_MIN)) ? (New <= Cur) : (New >= Cur);

endmodule

// File: rtl/window_peak_detect.sv
// Tracks the max or min of each N_WIN-sample window and reports the value
// and its in-window position one cycle after the window's last sample.
module window_peak_detect
   import dac_dig_pkg::*;
#(
   parameter int W     = 6,
   parameter int N_WIN = 16,
   localparam int IDX_W = clog2(N_WIN)
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             InValid,
   input  logic [W-1:0]     In,
   input  logic             Mode,
   input  logic             Clear,
   output logic             OutValid,
   output logic [W-1:0]     Out,
   output logic [IDX_W-1:0] OutIdx
);

   logic [IDX_W-1:0] cnt;
   logic [W-1:0]     run_val;
   logic [IDX_W-1:0] run_idx;
   logic             mode_q;
   logic             take;
   logic             last;

   assign last = (cnt == IDX_W'(N_WIN - 1));

   comp2_sel #(.W(W)) u_sel (
      .New  (In),
      .Cur  (run_val),
      .Mode (mode_q),
      .Take (take)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         cnt      <= '0;
         run_val  <= '0;
         run_idx  <= '0;
         mode_q   <= 1'b0;
         OutValid <= 1'b0;
         Out      <= '0;
         OutIdx   <= '0;
      end else begin
         OutValid <= 1'b0;
         if (Clear) begin
            cnt <= '0;
         end else if (InValid) begin
            cnt <= last ? '0 : cnt + 1'b1;
            // First sample seeds the window unconditionally and fixes its mode
            if (cnt == '0) begin
               run_val <= In;
               run_idx <= '0;
               mode_q  <= Mode;
            end else if (take) begin
               run_val <= In;
               run_idx <= cnt;
            end
            if (last) begin
               OutValid <= 1'b1;
               Out      <= take ? In  : run_val;
               OutIdx   <= take ? cnt : run_idx;
            end
         end
      end
   end

endmodule

// File: tb/tb_window_peak_detect.sv
// Scoreboard bench for window_peak_detect with W=6, N_WIN=4.
module tb_window_peak_detect;

   localparam int W     = 6;
   localparam int N_WIN = 4;
   localparam int IDX_W = 2;

   logic             Clk = 1'b0;
   logic             Rst, InValid, Mode, Clear;
   logic [W-1:0]     In;
   logic             OutValid;
   logic [W-1:0]     Out;
   logic [IDX_W-1:0] OutIdx;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_edge;

   logic [W-1:0]     exp_val[$];
   logic [IDX_W-1:0] exp_idx[$];
   int               exp_cyc[$];
   logic [W-1:0]     obs_val[$];
   logic [IDX_W-1:0] obs_idx[$];
   int               obs_cyc[$];

   window_peak_detect #(.W(W), .N_WIN(N_WIN)) dut (
      .Clk(Clk), .Rst(Rst), .InValid(InValid), .In(In), .Mode(Mode),
      .Clear(Clear), .OutValid(OutValid), .Out(Out), .OutIdx(OutIdx)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   always @(negedge Clk)
      if (OutValid) begin
         obs_val.push_back(Out);
         obs_idx.push_back(OutIdx);
         obs_cyc.push_back(cyc);
      end

   task automatic send(input logic [W-1:0] v, input logic m, input logic clr);
      InValid = 1'b1; In = v; Mode = m; Clear = clr;
      @(posedge Clk); #1;
      last_edge = cyc;
      InValid = 1'b0; Clear = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge Clk); #1; end
   endtask

   task automatic flush();
      exp_val.delete(); exp_idx.delete(); exp_cyc.delete();
      obs_val.delete(); obs_idx.delete(); obs_cyc.delete();
   endtask

   task automatic test_reset();
      flush();
      Rst = 1'b1; InValid = 1'b1; In = 6'd55; Mode = 1'b0; Clear = 1'b0;
      idle(3);
      checks++;
      if (OutValid !== 1'b0 || Out !== '0 || OutIdx !== '0) begin
         failures++;
         $display("FAIL reset_outputs got v=%b out=%0d idx=%0d exp v=0 out=0 idx=0", OutValid, Out, OutIdx);
      end
      Rst = 1'b0; InValid = 1'b0;
      idle(1);
   endtask

   task automatic test_max();
      logic [W-1:0] s[4] = '{6'd5, 6'd63, 6'd12, 6'd63};
      flush();
      foreach (s[i]) send(s[i], 1'b0, 1'b0);
      exp_val.push_back(6'd63); exp_idx.push_back(2'd3); exp_cyc.push_back(last_edge);
      idle(3);
      checks++;
      if (obs_val.size() != exp_val.size()) begin
         failures++;
         $display("FAIL max_pulses got=%0d exp=%0d", obs_val.size(), exp_val.size());
      end
      while (obs_val.size() > 0 && exp_val.size() > 0) begin
         checks++;
         if (obs_val[0] !== exp_val[0] || obs_idx[0] !== exp_idx[0] || obs_cyc[0] != exp_cyc[0]) begin
            failures++;
            $display("FAIL max_result got out=%0d idx=%0d cyc=%0d exp out=%0d idx=%0d cyc=%0d",
                     obs_val[0], obs_idx[0], obs_cyc[0], exp_val[0], exp_idx[0], exp_cyc[0]);
         end
         void'(obs_val.pop_front()); void'(obs_idx.pop_front()); void'(obs_cyc.pop_front());
         void'(exp_val.pop_front()); void'(exp_idx.pop_front()); void'(exp_cyc.pop_front());
      end
      checks++;
      if (Out !== 6'd63 || OutIdx !== 2'd3) begin
         failures++;
         $display("FAIL max_hold got out=%0d idx=%0d exp out=63 idx=3", Out, OutIdx);
      end
   endtask

   task automatic test_min_mode_toggle();
      logic [W-1:0] s[4] = '{6'd40, 6'd7, 6'd7, 6'd50};
      logic         m[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      flush();
      foreach (s[i]) send(s[i], m[i], 1'b0);
      exp_val.push_back(6'd7); exp_idx.push_back(2'd2); exp_cyc.push_back(last_edge);
      idle(3);
      checks++;
      if (obs_val.size() != exp_val.size()) begin
         failures++;
         $display("FAIL min_pulses got=%0d exp=%0d", obs_val.size(), exp_val.size());
      end
      while (obs_val.size() > 0 && exp_val.size() > 0) begin
         checks++;
         if (obs_val[0] !== exp_val[0] || obs_idx[0] !== exp_idx[0] || obs_cyc[0] != exp_cyc[0]) begin
            failures++;
            $display("FAIL min_result got out=%0d idx=%0d cyc=%0d exp out=%0d idx=%0d cyc=%0d",
                     obs_val[0], obs_idx[0], obs_cyc[0], exp_val[0], exp_idx[0], exp_cyc[0]);
         end
         void'(obs_val.pop_front()); void'(obs_idx.pop_front()); void'(obs_cyc.pop_front());
         void'(exp_val.pop_front()); void'(exp_idx.pop_front()); void'(exp_cyc.pop_front());
      end
   endtask

   task automatic test_back_to_back();
      flush();
      for (int i = 0; i < 8; i++) begin
         send(6'(i), 1'b0, 1'b0);
         if (i % 4 == 3) begin
            exp_val.push_back(6'(i)); exp_idx.push_back(2'd3); exp_cyc.push_back(last_edge);
         end
      end
      idle(3);
      checks++;
      if (obs_val.size() != 2) begin
         failures++;
         $display("FAIL b2b_pulses got=%0d exp=2", obs_val.size());
      end else begin
         checks++;
         if (obs_cyc[1] - obs_cyc[0] != 4) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d exp=4", obs_cyc[1] - obs_cyc[0]);
         end
      end
      while (obs_val.size() > 0 && exp_val.size() > 0) begin
         checks++;
         if (obs_val[0] !== exp_val[0] || obs_idx[0] !== exp_idx[0] || obs_cyc[0] != exp_cyc[0]) begin
            failures++;
            $display("FAIL b2b_result got out=%0d idx=%0d cyc=%0d exp out=%0d idx=%0d cyc=%0d",
                     obs_val[0], obs_idx[0], obs_cyc[0], exp_val[0], exp_idx[0], exp_cyc[0]);
         end
         void'(obs_val.pop_front()); void'(obs_idx.pop_front()); void'(obs_cyc.pop_front());
         void'(exp_val.pop_front()); void'(exp_idx.pop_front()); void'(exp_cyc.pop_front());
      end
   endtask

   task automatic test_clear();
      logic [W-1:0] s[4] = '{6'd9, 6'd1, 6'd2, 6'd3};
      flush();
      send(6'd60, 1'b0, 1'b0);
      send(6'd61, 1'b0, 1'b0);
      send(6'd62, 1'b0, 1'b0);
      send(6'd63, 1'b0, 1'b1);
      idle(3);
      checks++;
      if (obs_val.size() != 0) begin
         failures++;
         $display("FAIL clear_suppress got=%0d pulses exp=0", obs_val.size());
      end
      checks++;
      if (Out !== 6'd7 || OutIdx !== 2'd3) begin
         failures++;
         $display("FAIL clear_hold got out=%0d idx=%0d exp out=7 idx=3", Out, OutIdx);
      end
      flush();
      foreach (s[i]) send(s[i], 1'b0, 1'b0);
      exp_val.push_back(6'd9); exp_idx.push_back(2'd0); exp_cyc.push_back(last_edge);
      idle(3);
      checks++;
      if (obs_val.size() != exp_val.size()) begin
         failures++;
         $display("FAIL clear_next_pulses got=%0d exp=%0d", obs_val.size(), exp_val.size());
      end
      while (obs_val.size() > 0 && exp_val.size() > 0) begin
         checks++;
         if (obs_val[0] !== exp_val[0] || obs_idx[0] !== exp_idx[0] || obs_cyc[0] != exp_cyc[0]) begin
            failures++;
            $display("FAIL clear_next_result got out=%0d idx=%0d cyc=%0d exp out=%0d idx=%0d cyc=%0d",
                     obs_val[0], obs_idx[0], obs_cyc[0], exp_val[0], exp_idx[0], exp_cyc[0]);
         end
         void'(obs_val.pop_front()); void'(obs_idx.pop_front()); void'(obs_cyc.pop_front());
         void'(exp_val.pop_front()); void'(exp_idx.pop_front()); void'(exp_cyc.pop_front());
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] s[4] = '{6'd10, 6'd30, 6'd20, 6'd30};
      flush();
      send(6'd50, 1'b0, 1'b0);
      send(6'd51, 1'b0, 1'b0);
      Rst = 1'b1; InValid = 1'b1; In = 6'd63;
      idle(1);
      Rst = 1'b0; InValid = 1'b0;
      checks++;
      if (OutValid !== 1'b0 || Out !== '0 || OutIdx !== '0) begin
         failures++;
         $display("FAIL rst_mid_zero got v=%b out=%0d idx=%0d exp v=0 out=0 idx=0", OutValid, Out, OutIdx);
      end
      foreach (s[i]) send(s[i], 1'b0, 1'b0);
      exp_val.push_back(6'd30); exp_idx.push_back(2'd3); exp_cyc.push_back(last_edge);
      idle(3);
      checks++;
      if (obs_val.size() != exp_val.size()) begin
         failures++;
         $display("FAIL rst_mid_pulses got=%0d exp=%0d", obs_val.size(), exp_val.size());
      end
      while (obs_val.size() > 0 && exp_val.size() > 0) begin
         checks++;
         if (obs_val[0] !== exp_val[0] || obs_idx[0] !== exp_idx[0] || obs_cyc[0] != exp_cyc[0]) begin
            failures++;
            $display("FAIL rst_mid_result got out=%0d idx=%0d cyc=%0d exp out=%0d idx=%0d cyc=%0d",
                     obs_val[0], obs_idx[0], obs_cyc[0], exp_val[0], exp_idx[0], exp_cyc[0]);
         end
         void'(obs_val.pop_front()); void'(obs_idx.pop_front()); void'(obs_cyc.pop_front());
         void'(exp_val.pop_front()); void'(exp_idx.pop_front()); void'(exp_cyc.pop_front());
      end
   endtask

   task automatic test_gaps();
      logic [W-1:0] s[4] = '{6'd5, 6'd63, 6'd12, 6'd63};
      flush();
      foreach (s[i]) begin
         send(s[i], 1'b0, 1'b0);
         if (i < 3) idle(3);
      end
      exp_val.push_back(6'd63); exp_idx.push_back(2'd3); exp_cyc.push_back(last_edge);
      idle(3);
      checks++;
      if (obs_val.size() != exp_val.size()) begin
         failures++;
         $display("FAIL gaps_pulses got=%0d exp=%0d", obs_val.size(), exp_val.size());
      end
      while (obs_val.size() > 0 && exp_val.size() > 0) begin
         checks++;
         if (obs_val[0] !== exp_val[0] || obs_idx[0] !== exp_idx[0] || obs_cyc[0] != exp_cyc[0]) begin
            failures++;
            $display("FAIL gaps_result got out=%0d idx=%0d cyc=%0d exp out=%0d idx=%0d cyc=%0d",
                     obs_val[0], obs_idx[0], obs_cyc[0], exp_val[0], exp_idx[0], exp_cyc[0]);
         end
         void'(obs_val.pop_front()); void'(obs_idx.pop_front()); void'(obs_cyc.pop_front());
         void'(exp_val.pop_front()); void'(exp_idx.pop_front()); void'(exp_cyc.pop_front());
      end
   endtask

   task automatic test_min_ties();
      flush();
      for (int i = 0; i < 4; i++) send(6'd20, 1'b1, 1'b0);
      exp_val.push_back(6'd20); exp_idx.push_back(2'd3); exp_cyc.push_back(last_edge);
      idle(3);
      checks++;
      if (obs_val.size() != exp_val.size()) begin
         failures++;
         $display("FAIL ties_pulses got=%0d exp=%0d", obs_val.size(), exp_val.size());
      end
      while (obs_val.size() > 0 && exp_val.size() > 0) begin
         checks++;
         if (obs_val[0] !== exp_val[0] || obs_idx[0] !== exp_idx[0] || obs_cyc[0] != exp_cyc[0]) begin
            failures++;
            $display("FAIL ties_result got out=%0d idx=%0d cyc=%0d exp out=%0d idx=%0d cyc=%0d",
                     obs_val[0], obs_idx[0], obs_cyc[0], exp_val[0], exp_idx[0], exp_cyc[0]);
         end
         void'(obs_val.pop_front()); void'(obs_idx.pop_front()); void'(obs_cyc.pop_front());
         void'(exp_val.pop_front()); void'(exp_idx.pop_front()); void'(exp_cyc.pop_front());
      end
   endtask

   initial begin
      Rst = 1'b1; InValid = 1'b0; In = '0; Mode = 1'b0; Clear = 1'b0;
      #1;
      test_reset();
      test_max();
      test_min_mode_toggle();
      test_back_to_back();
      test_clear();
      test_reset_mid();
      test_gaps();
      test_min_ties();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
